regfile_read_arbiter: RTL and testbench

//   Shares one 32-entry register-file read port (5-bit address in, 32-bit word out) among NUM_REQ requesters.

---
 rtl/regfile_read_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares a single register-file read port among NUM_REQ requesters.
// Round-robin arbitration picks one requester per issue slot. The winning
// address is registered onto the read mux, left for one settle cycle, and
// the returned word is then captured. The word is held, tagged with the
// winner's index, until the consumer accepts it.

module regfile_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_FORCE = 1,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         mux_address,
    input  logic [DATA_WIDTH-1:0]         mux_data,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ID_WIDTH-1:0]     rr_ptr_q;
    logic [ID_WIDTH-1:0]     grant_id_q;
    logic [ADDR_WIDTH-1:0]   mux_address_q;
    logic                    rsp_valid_q;
    logic [ID_WIDTH-1:0]     rsp_id_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      grant_onehot;
    logic [ID_WIDTH-1:0]     winner;
    logic [ID_WIDTH-1:0]     scan_idx;
    logic                    any_valid;
    logic                    handshake;
    logic [ID_WIDTH-1:0]     rr_ptr_d;

    // Split the flat address bus into one address per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Round-robin scan: walk req_valid starting at rr_ptr, wrapping, and keep the first set bit.
    always_comb begin
        grant_onehot = '0;
        winner       = '0;
        any_valid    = 1'b0;
        scan_idx     = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid              = 1'b1;
                winner                 = scan_idx;
                grant_onehot[scan_idx] = 1'b1;
            end
            scan_idx = (scan_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // Grants are only offered while idle and out of reset; the pointer moves just past the winner.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE)) begin
            req_ready = grant_onehot;
        end
        handshake = |(req_valid & req_ready);
        rr_ptr_d  = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // Issue / settle / respond sequencer; reset abandons any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            mux_address_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        mux_address_q <= addr_arr[winner];
                        grant_id_q    <= winner;
                        rr_ptr_q      <= rr_ptr_d;
                        state_q       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if ((ZERO_FORCE != 0) && (mux_address_q == '0)) begin
                        rsp_data_q <= '0;
                    end else begin
                        rsp_data_q <= mux_data;
                    end
                    rsp_id_q    <= grant_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mux_address = mux_address_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter
// Self-checking bench for regfile_read_arbiter. Expected responses are queued
// as grants are made and compared when the consumer accepts them. A second
// instance with ZERO_FORCE=0 shares every input so the zero-register
// behaviour of both settings can be compared on the same transaction.

module tb_regfile_read_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    reqValid;
    logic [NR*AW-1:0] reqAddr;
    logic [NR-1:0]    reqReady, reqReady0;
    logic [AW-1:0]    muxAddress, muxAddress0;
    logic [DW-1:0]    muxData, muxManual;
    logic             autoData;
    logic             rspValid, rspValid0;
    logic [IW-1:0]    rspId, rspId0;
    logic [DW-1:0]    rspData, rspData0;
    logic             rspReady;
    logic             busy, busy0;

    int vectors     = 0;
    int miscompares = 0;
    int rrPtr       = 0;
    logic [IW+DW-1:0] expQ [$];
    logic [IW+DW-1:0] monEntry;

    regfile_read_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_FORCE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_addr(reqAddr),
        .req_ready(reqReady), .mux_address(muxAddress), .mux_data(muxData),
        .rsp_valid(rspValid), .rsp_id(rspId), .rsp_data(rspData),
        .rsp_ready(rspReady), .busy(busy)
    );

    regfile_read_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_FORCE(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_addr(reqAddr),
        .req_ready(reqReady0), .mux_address(muxAddress0), .mux_data(muxData),
        .rsp_valid(rspValid0), .rsp_id(rspId0), .rsp_data(rspData0),
        .rsp_ready(rspReady), .busy(busy0)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Register-file contents as seen through the read mux.
    function automatic logic [DW-1:0] dataFn(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ ({27'd0, a} * 32'h0001_0101);
    endfunction

    // Reference round-robin choice: first valid index at or after ptr, wrapping.
    function automatic int expWinner(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oneHot(input int w);
        return (w < 0) ? '0 : NR'(1 << w);
    endfunction

    // Read mux either follows the register-file model or a value forced by the bench.
    always_comb muxData = autoData ? dataFn(muxAddress) : muxManual;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] v, input logic [AW-1:0] a0,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] a3);
        reqAddr  = {a3, a2, a1, a0};
        reqValid = v;
    endtask

    // Check the grant against the reference arbiter and queue the response it should produce.
    task automatic grantAndPush(input string tag, input logic [DW-1:0] expData);
        int w;
        w = expWinner(reqValid, rrPtr);
        checkOutput(tag, reqReady, oneHot(w));
        if (w >= 0) begin
            expQ.push_back({IW'(w), expData});
            rrPtr = (w + 1) % NR;
        end
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        reqValid = '0;
        rspReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rrPtr = 0;
        expQ.delete();
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, expQ.size(), 0);
    endtask

    // Scoreboard: every accepted response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rspValid === 1'b1 && rspReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_unexpected", 1, 0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("rsp_id", rspId, monEntry[DW +: IW]);
                checkOutput("rsp_data", rspData, monEntry[DW-1:0]);
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        rst_n     = 1'b1;
        autoData  = 1'b1;
        muxManual = '0;
        rspReady  = 1'b0;
        applyStimulus(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
        #1;

        // Reset held with every requester asking.
        rst_n = 1'b0;
        #12;
        checkOutput("rst_req_ready", reqReady, 0);
        checkOutput("rst_rsp_valid", rspValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mux_address", muxAddress, 0);
        checkOutput("rst_rsp_data", rspData, 0);
        doReset();

        // Single read with arbitration recomputed as requests change.
        autoData = 1'b0;
        muxManual = '0;
        applyStimulus(4'b0011, 5'd9, 5'd10, 5'd7, 5'd12);
        #1;
        checkOutput("recompute_a", reqReady, oneHot(expWinner(4'b0011, rrPtr)));
        applyStimulus(4'b0100, 5'd9, 5'd10, 5'd7, 5'd12);
        #1;
        checkOutput("single_ready", reqReady, 4'b0100);
        grantAndPush("single_grant", 32'hDEADBEEF);
        @(posedge clk); #1;
        reqValid  = '0;
        muxManual = 32'hDEADBEEF;
        checkOutput("single_mux_addr", muxAddress, 7);
        checkOutput("single_busy", busy, 1);
        checkOutput("single_no_ready", reqReady, 0);
        @(posedge clk); #1;
        muxManual = '0;
        checkOutput("single_rsp_valid", rspValid, 1);
        checkOutput("single_rsp_id", rspId, 2);
        checkOutput("single_rsp_data", rspData, 32'hDEADBEEF);
        rspReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("single_accept", rspValid, 0);
        rspReady = 1'b0;
        waitDrain("single_drain");

        // Round robin with all requesters held high.
        doReset();
        autoData = 1'b1;
        rspReady = 1'b1;
        applyStimulus(4'b1111, 5'd3, 5'd11, 5'd19, 5'd31);
        #1;
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                gap = 1;
                while (reqReady == 0 && gap < 10) begin
                    @(posedge clk); #1;
                    gap++;
                end
                checkOutput("rr_gap", gap, 3);
            end
            checkOutput("rr_order", reqReady, 4'b0001 << (g % 4));
            grantAndPush("rr_grant", dataFn(reqAddr[(g % 4)*AW +: AW]));
            @(posedge clk); #1;
        end
        reqValid = '0;
        waitDrain("rr_drain");
        rspReady = 1'b0;

        // Backpressure: response and mux address hold while the consumer stalls.
        autoData  = 1'b0;
        muxManual = 32'h1111_1111;
        applyStimulus(4'b0010, 5'd1, 5'd5, 5'd2, 5'd3);
        #1;
        grantAndPush("bp_grant", 32'h1111_1111);
        @(posedge clk); #1;
        reqValid = 4'b1111;
        checkOutput("bp_mux_addr", muxAddress, 5);
        @(posedge clk); #1;
        checkOutput("bp_rsp_valid", rspValid, 1);
        for (int c = 0; c < 5; c++) begin
            muxManual = $urandom;
            @(posedge clk); #1;
            checkOutput("bp_hold_valid", rspValid, 1);
            checkOutput("bp_hold_id", rspId, 1);
            checkOutput("bp_hold_data", rspData, 32'h1111_1111);
            checkOutput("bp_hold_addr", muxAddress, 5);
            checkOutput("bp_no_ready", reqReady, 0);
        end
        reqValid = '0;
        rspReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_accept_valid", rspValid, 0);
        checkOutput("bp_accept_idle", busy, 0);
        rspReady = 1'b0;
        waitDrain("bp_drain");

        // Zero register with and without forcing.
        muxManual = 32'h1234_5678;
        applyStimulus(4'b0001, 5'd0, 5'd6, 5'd6, 5'd6);
        #1;
        grantAndPush("zero_grant", 32'h0);
        @(posedge clk); #1;
        reqValid = '0;
        @(posedge clk); #1;
        checkOutput("zero_forced", rspData, 0);
        checkOutput("zero_plain_valid", rspValid0, 1);
        checkOutput("zero_plain_data", rspData0, 32'h1234_5678);
        rspReady = 1'b1;
        waitDrain("zero_drain");
        rspReady = 1'b0;

        // Reset during the settle cycle abandons the read.
        doReset();
        autoData = 1'b1;
        rspReady = 1'b1;
        applyStimulus(4'b0100, 5'd8, 5'd13, 5'd4, 5'd21);
        #1;
        checkOutput("mid_grant", reqReady, 4'b0100);
        @(posedge clk); #1;
        reqValid = '0;
        checkOutput("mid_settle_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_mux_addr", muxAddress, 0);
        checkOutput("mid_rst_ready", reqReady, 0);
        rst_n = 1'b1;
        rrPtr = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("mid_no_rsp", rspValid, 0);
        end
        reqValid = 4'b1010;
        #1;
        checkOutput("mid_first_grant", reqReady, 4'b0010);
        grantAndPush("mid_grant_model", dataFn(5'd13));
        @(posedge clk); #1;
        reqValid = '0;
        waitDrain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
